uart_tx_serializer: RTL and testbench

- UART transmitter stage directly downstream of the system TX controller, in the UART TX clock domain (one clock = one bit period).
- Accepts a parallel byte via a valid level plus registered busy handshake.
- Serializes the byte as start bit, data bits LSB first, optional parity bit, stop bit onto the serial line.

---
 rtl/uart_tx_serializer_if.sv | 29 ++
 rtl/uart_tx_serializer.sv | 99 +++++++++
 tb/tb_uart_tx_serializer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - handshake and serial line bundle for uart_tx_serializer
interface uart_tx_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] tx_data_in;
   logic             tx_data_valid_in;
   logic             parity_enable_in;
   logic             parity_type_in;
   logic             tx_out;
   logic             busy_out;

   modport master (
      output tx_data_in,
      output tx_data_valid_in,
      output parity_enable_in,
      output parity_type_in,
      input  tx_out,
      input  busy_out
   );

   modport slave (
      input  tx_data_in,
      input  tx_data_valid_in,
      input  parity_enable_in,
      input  parity_type_in,
      output tx_out,
      output busy_out
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer: start, LSB-first data, optional parity, stop
module uart_tx_serializer #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   uart_tx_serializer_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shift;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic             par_en;
   logic             par_bit;
   logic             tx_q;
   logic             busy_q;

   assign cnt_next = cnt + 1'b1;

   // Outputs are driven from the next-state decision so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         shift   <= '0;
         cnt     <= '0;
         par_en  <= 1'b0;
         par_bit <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.tx_data_valid_in) begin
                  shift   <= bus.tx_data_in;
                  par_en  <= bus.parity_enable_in;
                  par_bit <= (^bus.tx_data_in) ^ bus.parity_type_in;
                  state   <= START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            START: begin
               state  <= DATA;
               cnt    <= '0;
               tx_q   <= shift[0];
               busy_q <= 1'b1;
            end
            DATA: begin
               busy_q <= 1'b1;
               if (cnt == LAST) begin
                  if (par_en) begin
                     state <= PARITY;
                     tx_q  <= par_bit;
                  end else begin
                     state <= STOP;
                     tx_q  <= 1'b1;
                  end
               end else begin
                  cnt  <= cnt_next;
                  tx_q <= shift[cnt_next];
               end
            end
            PARITY: begin
               state  <= STOP;
               tx_q   <= 1'b1;
               busy_q <= 1'b1;
            end
            STOP: begin
               // Always pass through IDLE so busy drops for at least one cycle between frames.
               state  <= IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx_out   = tx_q;
   assign bus.busy_out = busy_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - randomized self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;
   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_err;

   uart_tx_serializer_if #(.WIDTH(8)) bus ();

   uart_tx_serializer #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Line bit sequence of one frame, first bit on the line in bit 0.
   function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt,
                                       output int len, output logic [15:0] v);
      int ones;
      v    = '0;
      len  = 0;
      ones = $countones(d);
      v[len] = 1'b0;
      len++;
      for (int i = 0; i < 8; i++) begin
         v[len] = d[i];
         len++;
      end
      if (pe) begin
         v[len] = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
         len++;
      end
      v[len] = 1'b1;
      len++;
   endfunction

   task automatic capture(output int n, output logic [15:0] v);
      n = 0;
      v = '0;
      while (bus.busy_out === 1'b1 && n < 16) begin
         v[n] = bus.tx_out;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_high(input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (bus.busy_out !== 1'b1 && k < 30);
      check({tag, "_latency"}, k, 1);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                            input int fixed_len, input logic [15:0] fixed_v);
      int          n, elen;
      logic [15:0] v, ev;
      @(negedge clk);
      bus.tx_data_in       = d;
      bus.parity_enable_in = pe;
      bus.parity_type_in   = pt;
      bus.tx_data_valid_in = 1'b1;
      wait_high(tag);
      bus.tx_data_valid_in = 1'b0;
      bus.tx_data_in       = ~d;
      bus.parity_enable_in = ~pe;
      bus.parity_type_in   = ~pt;
      capture(n, v);
      if (fixed_len > 0) begin
         elen = fixed_len;
         ev   = fixed_v;
      end else begin
         build_frame(d, pe, pt, elen, ev);
      end
      check({tag, "_len"}, n, elen);
      check({tag, "_bits"}, v, ev);
   endtask

   initial begin
      int          n, elen, gap;
      logic [15:0] v, ev;
      n_cmp = 0;
      n_err = 0;
      bus.tx_data_in       = '0;
      bus.tx_data_valid_in = 1'b0;
      bus.parity_enable_in = 1'b0;
      bus.parity_type_in   = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", bus.tx_out, 1);
      check("reset_busy", bus.busy_out, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 10, 16'h034A);
      run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 0, '0);
      run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 0, '0);
      run_frame("h07_odd", 8'h07, 1'b1, 1'b1, 11, 16'h040E);

      for (int i = 0; i < 20; i++) begin
         run_frame($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom), 1'($urandom), 0, '0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Back-to-back with valid held; inputs change mid-frame.
      @(negedge clk);
      bus.tx_data_in       = 8'h3C;
      bus.parity_enable_in = 1'b0;
      bus.parity_type_in   = 1'b0;
      bus.tx_data_valid_in = 1'b1;
      wait_high("b2b_first");
      bus.tx_data_in       = 8'hC3;
      bus.parity_enable_in = 1'b1;
      capture(n, v);
      build_frame(8'h3C, 1'b0, 1'b0, elen, ev);
      check("b2b_f1_len", n, elen);
      check("b2b_f1_bits", v, ev);
      gap = 0;
      while (bus.busy_out !== 1'b1 && gap < 10) begin
         gap++;
         @(negedge clk);
      end
      check("b2b_gap", gap, 1);
      bus.tx_data_valid_in = 1'b0;
      capture(n, v);
      build_frame(8'hC3, 1'b1, 1'b0, elen, ev);
      check("b2b_f2_len", n, elen);
      check("b2b_f2_bits", v, ev);
      repeat (2) @(negedge clk);

      // Reset during data bit 3 of 0xFF, then load on first edge after release.
      bus.tx_data_in       = 8'hFF;
      bus.parity_enable_in = 1'b0;
      bus.tx_data_valid_in = 1'b1;
      wait_high("rst_frame");
      bus.tx_data_valid_in = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", bus.busy_out, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_tx", bus.tx_out, 1);
      check("async_rst_busy", bus.busy_out, 0);
      @(negedge clk);
      check("held_rst_busy", bus.busy_out, 0);
      @(negedge clk);
      reset_n              = 1'b1;
      bus.tx_data_in       = 8'h55;
      bus.parity_enable_in = 1'b0;
      bus.tx_data_valid_in = 1'b1;
      @(negedge clk);
      bus.tx_data_valid_in = 1'b0;
      check("first_edge_busy", bus.busy_out, 1);
      check("first_edge_start", bus.tx_out, 0);
      capture(n, v);
      build_frame(8'h55, 1'b0, 1'b0, elen, ev);
      check("post_rst_len", n, elen);
      check("post_rst_bits", v, ev);
      @(negedge clk);
      check("final_idle_tx", bus.tx_out, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
